// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the WISC memory stage.
package mem_stage_pkg;

  // Access FSM: IDLE issues a request, WAIT holds it until done or timeout.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned REG_W       = 3;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned TIMEOUT_DEF = 63;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] memd;
    logic [REG_W-1:0]  wrr;
    logic              regwrite;
    logic              memtoreg;
    logic              halt;
  } memwb_t;

  // True in the cycle where the request has been outstanding 'limit' cycles.
  // The IDLE issue cycle counts as the first; WAIT starts the counter at 0.
  function automatic logic cnt_expired(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] limit);
    return ((cnt + 6'd1) == limit);
  endfunction

endpackage

// File: rtl/mem_stage_memwb.sv
// MEM/WB pipeline register: loads EX/MEM fields, or a bubble while stalled.
module memwb_reg
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              memd_we,
  input  logic [DATA_W-1:0] memd_in,
  input  memwb_t            d,
  output memwb_t            q
);

  memwb_t q_r;

  // Register update: bubble clears WB controls and holds data; load copies EX/MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r.alu      <= 16'h0000;
      q_r.memd     <= 16'h0000;
      q_r.wrr      <= 3'd0;
      q_r.regwrite <= 1'b0;
      q_r.memtoreg <= 1'b0;
      q_r.halt     <= 1'b0;
    end else if (bubble) begin
      q_r.regwrite <= 1'b0;
      q_r.memtoreg <= 1'b0;
      q_r.halt     <= 1'b0;
    end else begin
      q_r.alu      <= d.alu;
      q_r.wrr      <= d.wrr;
      q_r.regwrite <= d.regwrite;
      q_r.memtoreg <= d.memtoreg;
      q_r.halt     <= d.halt;
      if (memd_we) begin
        q_r.memd <= memd_in;
      end else begin
        q_r.memd <= q_r.memd;
      end
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mem_stage.sv
// WISC memory stage: request handshake FSM, stall generation, error flagging.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ALUO_EXMEM,
  input  logic [DATA_W-1:0] Rd2_EXMEM,
  input  logic [REG_W-1:0]  WrR_EXMEM,
  input  logic              RegWrite_EXMEM,
  input  logic              MemtoReg_EXMEM,
  input  logic              MemRead_EXMEM,
  input  logic              MemWrite_EXMEM,
  input  logic              Dump_EXMEM,
  input  logic              halt_EXMEM,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_dump,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              stall,
  output logic [DATA_W-1:0] ALUO_MEMWB,
  output logic [DATA_W-1:0] MemD_MEMWB,
  output logic [REG_W-1:0]  WrR_MEMWB,
  output logic              RegWrite_MEMWB,
  output logic              MemtoReg_MEMWB,
  output logic              halt_MEMWB,
  output logic              err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              err_r, err_s;
  logic              op_s, bad_s, hit_s, strobe_s, complete_s, done_acc_s;
  logic              stall_s, memd_we_s;
  logic [DATA_W-1:0] memd_in_s;
  memwb_t            exmem_s, memwb_s;

  // Access decode, FSM next state, counter and completion qualifiers.
  always_comb begin
    op_s       = (MemRead_EXMEM ^ MemWrite_EXMEM) & ~ALUO_EXMEM[0];
    bad_s      = (MemRead_EXMEM | MemWrite_EXMEM) & ~op_s;
    state_s    = state_r;
    cnt_s      = cnt_r;
    hit_s      = 1'b0;
    strobe_s   = 1'b0;
    complete_s = 1'b0;
    done_acc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (op_s) begin
          strobe_s = 1'b1;
          if (mem_done) begin
            complete_s = 1'b1;
            done_acc_s = 1'b1;
          end else begin
            state_s = WAIT;
            cnt_s   = 6'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!op_s) begin
          // EX/MEM is frozen while waiting; recover if it ever is not.
          state_s = IDLE;
          cnt_s   = 6'd0;
        end else if (cnt_expired(cnt_r, TIMEOUT_C)) begin
          hit_s      = 1'b1;
          complete_s = 1'b1;
          state_s    = IDLE;
          cnt_s      = 6'd0;
        end else begin
          strobe_s = 1'b1;
          cnt_s    = cnt_r + 6'd1;
          if (mem_done) begin
            complete_s = 1'b1;
            done_acc_s = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = WAIT;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 6'd0;
      end
    endcase
    stall_s   = op_s & ~mem_done & ~hit_s;
    memd_we_s = complete_s & (MemRead_EXMEM | hit_s);
    memd_in_s = hit_s ? 16'h0000 : mem_rdata;
    err_s     = err_r | bad_s | hit_s | (done_acc_s & mem_err);
  end

  // FSM state, timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  // Strobes and stall are gated by reset so they drop without a clock edge.
  assign mem_rd    = strobe_s & MemRead_EXMEM & rst;
  assign mem_wr    = strobe_s & MemWrite_EXMEM & rst;
  assign stall     = stall_s & rst;
  assign mem_addr  = ALUO_EXMEM;
  assign mem_wdata = Rd2_EXMEM;
  assign mem_dump  = Dump_EXMEM;
  assign err       = err_r;

  assign exmem_s.alu      = ALUO_EXMEM;
  assign exmem_s.memd     = 16'h0000;
  assign exmem_s.wrr      = WrR_EXMEM;
  assign exmem_s.regwrite = RegWrite_EXMEM;
  assign exmem_s.memtoreg = MemtoReg_EXMEM;
  assign exmem_s.halt     = halt_EXMEM;

  memwb_reg u_memwb (
    .clk     (clk),
    .rst     (rst),
    .bubble  (stall_s),
    .memd_we (memd_we_s),
    .memd_in (memd_in_s),
    .d       (exmem_s),
    .q       (memwb_s)
  );

  assign ALUO_MEMWB     = memwb_s.alu;
  assign MemD_MEMWB     = memwb_s.memd;
  assign WrR_MEMWB      = memwb_s.wrr;
  assign RegWrite_MEMWB = memwb_s.regwrite;
  assign MemtoReg_MEMWB = memwb_s.memtoreg;
  assign halt_MEMWB     = memwb_s.halt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM;
  logic [2:0]  WrR_EXMEM;
  logic        RegWrite_EXMEM, MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM;
  logic        Dump_EXMEM, halt_EXMEM;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr, mem_dump;
  logic        mem_done, mem_err;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] ALUO_MEMWB, MemD_MEMWB;
  logic [2:0]  WrR_MEMWB;
  logic        RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB, err;

  int errors = 0;
  int checks = 0;
  int n;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .WrR_EXMEM(WrR_EXMEM),
    .RegWrite_EXMEM(RegWrite_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM),
    .MemRead_EXMEM(MemRead_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
    .Dump_EXMEM(Dump_EXMEM), .halt_EXMEM(halt_EXMEM),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dump(mem_dump), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .stall(stall), .ALUO_MEMWB(ALUO_MEMWB), .MemD_MEMWB(MemD_MEMWB),
    .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
    .MemtoReg_MEMWB(MemtoReg_MEMWB), .halt_MEMWB(halt_MEMWB), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ALUO_EXMEM = 16'h0000; Rd2_EXMEM = 16'h0000; WrR_EXMEM = 3'd0;
    RegWrite_EXMEM = 1'b0; MemtoReg_EXMEM = 1'b0; MemRead_EXMEM = 1'b0;
    MemWrite_EXMEM = 1'b0; Dump_EXMEM = 1'b0; halt_EXMEM = 1'b0;
    mem_done = 1'b0; mem_rdata = 16'h0000; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    check("reset_alu", ALUO_MEMWB, 16'h0000);
    check("reset_memd", MemD_MEMWB, 16'h0000);
    check("reset_regwrite", RegWrite_MEMWB, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_stall", stall, 1'b0);
    tick();
    rst = 1'b1;

    // Non-memory op passes through in one cycle.
    ALUO_EXMEM = 16'h1234; RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd3;
    #1;
    check("alu_stall", stall, 1'b0);
    check("alu_rd", mem_rd, 1'b0);
    tick();
    check("alu_passthru", ALUO_MEMWB, 16'h1234);
    check("alu_wrr", WrR_MEMWB, 3'd3);
    check("alu_regwrite", RegWrite_MEMWB, 1'b1);

    // Load with latency 3.
    ALUO_EXMEM = 16'h0040; MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1;
    RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd5;
    #1;
    check("ld_rd", mem_rd, 1'b1);
    check("ld_addr", mem_addr, 16'h0040);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!stall) break;
      n++;
      tick();
      check("ld_bubble", RegWrite_MEMWB, 1'b0);
      check("ld_bubble_alu_hold", ALUO_MEMWB, 16'h1234);
      if (n == 3) begin
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
      end
      #1;
    end
    check("ld_stall_cycles", n, 3);
    check("ld_rd_on_done", mem_rd, 1'b1);
    tick();
    mem_done = 1'b0;
    check("ld_memd", MemD_MEMWB, 16'hBEEF);
    check("ld_regwrite", RegWrite_MEMWB, 1'b1);
    check("ld_alu", ALUO_MEMWB, 16'h0040);
    check("ld_memtoreg", MemtoReg_MEMWB, 1'b1);

    // Zero-latency store, then back-to-back load.
    ALUO_EXMEM = 16'h0010; Rd2_EXMEM = 16'hCAFE; MemRead_EXMEM = 1'b0;
    MemWrite_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b0; RegWrite_EXMEM = 1'b0;
    mem_done = 1'b1;
    #1;
    check("st_wr", mem_wr, 1'b1);
    check("st_rd", mem_rd, 1'b0);
    check("st_wdata", mem_wdata, 16'hCAFE);
    check("st_stall", stall, 1'b0);
    tick();
    check("st_alu", ALUO_MEMWB, 16'h0010);
    check("st_memd_hold", MemD_MEMWB, 16'hBEEF);
    ALUO_EXMEM = 16'h0020; MemWrite_EXMEM = 1'b0; MemRead_EXMEM = 1'b1;
    RegWrite_EXMEM = 1'b1; mem_done = 1'b0;
    #1;
    check("b2b_rd", mem_rd, 1'b1);
    check("b2b_wr", mem_wr, 1'b0);
    check("b2b_stall", stall, 1'b1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h1111;
    #1;
    check("b2b_done_stall", stall, 1'b0);
    tick();
    idle_inputs();
    check("b2b_memd", MemD_MEMWB, 16'h1111);
    check("b2b_err", err, 1'b0);

    // Misaligned load.
    ALUO_EXMEM = 16'h0041; MemRead_EXMEM = 1'b1;
    #1;
    check("mis_rd", mem_rd, 1'b0);
    check("mis_stall", stall, 1'b0);
    tick();
    idle_inputs();
    check("mis_err", err, 1'b1);
    check("mis_flow", ALUO_MEMWB, 16'h0041);
    tick();
    check("mis_sticky", err, 1'b1);

    // Illegal read+write, after a fresh reset.
    do_reset();
    check("rst_clears_err", err, 1'b0);
    ALUO_EXMEM = 16'h0044; MemRead_EXMEM = 1'b1; MemWrite_EXMEM = 1'b1;
    #1;
    check("ill_rd", mem_rd, 1'b0);
    check("ill_wr", mem_wr, 1'b0);
    check("ill_stall", stall, 1'b0);
    tick();
    idle_inputs();
    check("ill_err", err, 1'b1);

    // Timeout: seed MemD with a nonzero load first.
    do_reset();
    ALUO_EXMEM = 16'h0002; MemRead_EXMEM = 1'b1; mem_done = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    check("seed_memd", MemD_MEMWB, 16'h5A5A);
    ALUO_EXMEM = 16'h0080; RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd6;
    mem_done = 1'b0; mem_rdata = 16'h7777;
    #1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stall) break;
      n++;
      tick();
      #1;
    end
    check("to_stall_cycles", n, 63);
    check("to_strobe_drop", mem_rd, 1'b0);
    tick();
    idle_inputs();
    check("to_err", err, 1'b1);
    check("to_memd_zero", MemD_MEMWB, 16'h0000);
    check("to_regwrite", RegWrite_MEMWB, 1'b1);
    check("to_wrr", WrR_MEMWB, 3'd6);
    #1;
    check("to_resume", stall, 1'b0);

    // Memory error returned with done.
    do_reset();
    ALUO_EXMEM = 16'h0030; MemRead_EXMEM = 1'b1; mem_done = 1'b1; mem_err = 1'b1;
    #1;
    check("merr_pre", err, 1'b0);
    tick();
    idle_inputs();
    check("merr_err", err, 1'b1);

    // Reset mid-WAIT, then a stray done.
    do_reset();
    ALUO_EXMEM = 16'h00A0; MemRead_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd2;
    mem_done = 1'b1; mem_rdata = 16'h4321;
    tick();
    mem_done = 1'b0;
    tick();
    tick();
    check("mid_stall_before", stall, 1'b1);
    check("mid_rd_before", mem_rd, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_rd", mem_rd, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_alu", ALUO_MEMWB, 16'h0000);
    check("mid_rst_memd", MemD_MEMWB, 16'h0000);
    check("mid_rst_wrr", WrR_MEMWB, 3'd0);
    idle_inputs();
    tick();
    rst = 1'b1;
    mem_done = 1'b1; mem_rdata = 16'hFFFF; mem_err = 1'b1;
    #1;
    check("stray_rd", mem_rd, 1'b0);
    tick();
    idle_inputs();
    check("stray_memd", MemD_MEMWB, 16'h0000);
    check("stray_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
